// File: rtl/gpio_pkg.sv
// Shared constants for the gpio peripheral: register word offsets and default pin count.
package gpio_pkg;

  localparam int unsigned GPIO_W_DEFAULT = 16;
  localparam int unsigned BUS_W          = 32;

  localparam logic [2:0] GPIO_OFF_IN       = 3'd0;
  localparam logic [2:0] GPIO_OFF_OUT      = 3'd1;
  localparam logic [2:0] GPIO_OFF_SET      = 3'd2;
  localparam logic [2:0] GPIO_OFF_CLR      = 3'd3;
  localparam logic [2:0] GPIO_OFF_TGL      = 3'd4;
  localparam logic [2:0] GPIO_OFF_IRQ_EN   = 3'd5;
  localparam logic [2:0] GPIO_OFF_IRQ_STAT = 3'd6;

endpackage

// File: rtl/gpio_edge_detect.sv
// Rising-edge detector: remembers last cycle's pins and flags 0->1 transitions.
module gpio_edge_detect #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '0;
    else      prev <= din;
  end

  // prev clears on reset, so pins already high count as a rise on the first edge
  assign rise = din & ~prev;

endmodule

// File: rtl/gpio.sv
// Memory-mapped GPIO: input view, output register with set/clear/toggle aliases.
// Rising-edge interrupts are built only when GPIO_IRQ_EN is defined.
module gpio
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_W = GPIO_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bSel,
  input  logic              bWrite,
  input  logic [31:0]       bAddr,
  input  logic [31:0]       bWData,
  output logic [31:0]       bRData,
  input  logic [GPIO_W-1:0] gpioInput,
  output logic [GPIO_W-1:0] gpioOutput,
  output logic              irq
);

  logic [2:0]        wordIdx;
  logic              wrEn;
  logic [GPIO_W-1:0] wData;
  logic [GPIO_W-1:0] outReg;
  logic [GPIO_W-1:0] outNext;
  logic [GPIO_W-1:0] rdData;
  logic              unusedBits;

  assign wordIdx    = bAddr[4:2];
  assign wrEn       = bSel & bWrite;
  assign wData      = bWData[GPIO_W-1:0];
  assign unusedBits = ^{bAddr[31:5], bAddr[1:0], bWData};

  // Output register next value, including the atomic alias writes
  always_comb begin
    outNext = outReg;
    if (wrEn) begin
      case (wordIdx)
        GPIO_OFF_OUT: outNext = wData;
        GPIO_OFF_SET: outNext = outReg | wData;
        GPIO_OFF_CLR: outNext = outReg & ~wData;
        GPIO_OFF_TGL: outNext = outReg ^ wData;
        default:      outNext = outReg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) outReg <= '0;
    else      outReg <= outNext;
  end

  assign gpioOutput = outReg;

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] irqEn;
  logic [GPIO_W-1:0] irqEnNext;
  logic [GPIO_W-1:0] irqStat;
  logic [GPIO_W-1:0] irqStatNext;

  gpio_edge_detect #(.W(GPIO_W)) uEdge (
    .clk  (clk),
    .rst  (rst),
    .din  (gpioInput),
    .rise (rise)
  );

  // Edge set is OR-ed in after the W1C so a same-cycle edge wins
  always_comb begin
    irqEnNext   = irqEn;
    irqStatNext = irqStat;
    if (wrEn && (wordIdx == GPIO_OFF_IRQ_EN))   irqEnNext   = wData;
    if (wrEn && (wordIdx == GPIO_OFF_IRQ_STAT)) irqStatNext = irqStat & ~wData;
    irqStatNext = irqStatNext | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irqEn   <= '0;
      irqStat <= '0;
    end else begin
      irqEn   <= irqEnNext;
      irqStat <= irqStatNext;
    end
  end

  assign irq = |(irqStat & irqEn);
`else
  assign irq = 1'b0;
`endif

  // Zero-latency read mux; deselected, write-only and unmapped offsets read 0
  always_comb begin
    rdData = '0;
    if (bSel) begin
      case (wordIdx)
        GPIO_OFF_IN:       rdData = gpioInput;
        GPIO_OFF_OUT:      rdData = outReg;
`ifdef GPIO_IRQ_EN
        GPIO_OFF_IRQ_EN:   rdData = irqEn;
        GPIO_OFF_IRQ_STAT: rdData = irqStat;
`endif
        default:           rdData = '0;
      endcase
    end
  end

  assign bRData = BUS_W'(rdData);

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench for gpio: directed register-map checks plus randomized bus traffic
// against a behavioural model. Define GPIO_IRQ_EN to exercise the interrupt build.
module tb_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic        bSel;
  logic        bWrite;
  logic [31:0] bAddr;
  logic [31:0] bWData;
  logic [31:0] bRData;
  logic [15:0] gpioInput;
  logic [15:0] gpioOutput;
  logic        irq;

  int nCompared   = 0;
  int nMismatched = 0;

  // Behavioural model state
  logic [15:0] mOut, mEn, mStat, mPrev;

  gpio #(.GPIO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bSel       (bSel),
    .bWrite     (bWrite),
    .bAddr      (bAddr),
    .bWData     (bWData),
    .bRData     (bRData),
    .gpioInput  (gpioInput),
    .gpioOutput (gpioOutput),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mOut = '0; mEn = '0; mStat = '0; mPrev = '0;
  endfunction

  function automatic logic [31:0] modelRead(input logic sel, input logic [2:0] off);
    if (!sel) return 32'h0;
    case (off)
      3'd0:    return {16'h0, gpioInput};
      3'd1:    return {16'h0, mOut};
      3'd5:    return {16'h0, mEn};
      3'd6:    return {16'h0, mStat};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelIrq();
    return |(mStat & mEn);
  endfunction

  // One rising edge; the model applies whatever the bench is driving at that edge
  task automatic tick();
    logic [15:0] d;
    logic [15:0] rise;
    @(posedge clk);
    if (rst) begin
      d    = bWData[15:0];
      rise = gpioInput & ~mPrev;
      mPrev = gpioInput;
      if (bSel && bWrite) begin
        case (bAddr[4:2])
          3'd1: mOut = d;
          3'd2: mOut = mOut | d;
          3'd3: mOut = mOut & ~d;
          3'd4: mOut = mOut ^ d;
`ifdef GPIO_IRQ_EN
          3'd5: mEn = d;
          3'd6: mStat = mStat & ~d;
`endif
          default: ;
        endcase
      end
`ifdef GPIO_IRQ_EN
      mStat = mStat | rise;
`endif
    end
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bSel = 1'b1; bWrite = 1'b1; bAddr = addr; bWData = data;
    tick();
    bSel = 1'b0; bWrite = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bSel = 1'b1; bWrite = 1'b0; bAddr = addr;
    #1 data = bRData;
    bSel = 1'b0;
  endtask

  // Change pins, check the IN view in the same cycle, then let the edge pass
  task automatic setInput(input logic [15:0] v);
    @(negedge clk);
    gpioInput = v;
    bSel = 1'b1; bWrite = 1'b0; bAddr = 32'h0;
    #1 checkVal("inLive", bRData, {16'h0, v});
    bSel = 1'b0;
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b0; bSel = 1'b0; bWrite = 1'b0; bAddr = '0; bWData = '0; gpioInput = '0;
    modelReset();
    #20 rst = 1'b1;
    #1;
    checkVal("rstOut", {16'h0, gpioOutput}, 32'h0);
    checkVal("rstIrq", {31'h0, irq}, 32'h0);
    busRead(32'h4, rd);
    checkVal("rstRdOut", rd, 32'h0);

    busWrite(32'h4, 32'h0000AAAA);
    checkVal("wrOutPins", {16'h0, gpioOutput}, 32'h0000AAAA);
    busRead(32'h4, rd);
    checkVal("wrOutRd", rd, 32'h0000AAAA);

    setInput(16'h55AA);
    setInput(16'hF0F0);
    busRead(32'hFFFF_FFE0, rd);
    checkVal("inAliasHiAddr", rd, 32'h0000F0F0);

    busWrite(32'h8, 32'h0000000F);
    checkVal("set", {16'h0, gpioOutput}, 32'h0000AAAF);
    busWrite(32'hC, 32'h0000A000);
    checkVal("clr", {16'h0, gpioOutput}, 32'h00000AAF);
    busWrite(32'h10, 32'hFFFF00FF);
    checkVal("tgl", {16'h0, gpioOutput}, 32'h00000A50);
    busRead(32'h8, rd);  checkVal("rdSet", rd, 32'h0);
    busRead(32'hC, rd);  checkVal("rdClr", rd, 32'h0);
    busRead(32'h10, rd); checkVal("rdTgl", rd, 32'h0);
    busRead(32'h1C, rd); checkVal("rdUnmapped", rd, 32'h0);

    @(negedge clk);
    bSel = 1'b0; bWrite = 1'b1; bAddr = 32'h4; bWData = 32'h0000FFFF;
    tick();
    bWrite = 1'b0;
    checkVal("noSelWr", {16'h0, gpioOutput}, 32'h00000A50);
    @(negedge clk);
    bAddr = 32'h4;
    #1 checkVal("noSelRd", bRData, 32'h0);

`ifdef GPIO_IRQ_EN
    setInput(16'h0000);
    busWrite(32'h18, 32'h0000FFFF);
    busWrite(32'h14, 32'h00000001);
    checkVal("irqIdle", {31'h0, irq}, 32'h0);
    setInput(16'h0001);
    busRead(32'h18, rd);
    checkVal("irqStat0", rd, 32'h1);
    checkVal("irqHigh", {31'h0, irq}, 32'h1);
    busWrite(32'h18, 32'h00000001);
    checkVal("irqW1c", {31'h0, irq}, 32'h0);
    setInput(16'h0003);
    busRead(32'h18, rd);
    checkVal("irqStat1", rd, 32'h2);
    checkVal("irqMasked", {31'h0, irq}, 32'h0);
    // Edge and W1C on the same bit in one cycle: the set wins
    @(negedge clk);
    gpioInput = 16'h0007;
    bSel = 1'b1; bWrite = 1'b1; bAddr = 32'h18; bWData = 32'h4;
    tick();
    bSel = 1'b0; bWrite = 1'b0;
    busRead(32'h18, rd);
    checkVal("irqSetWins", rd, 32'h6);
`else
    busWrite(32'h14, 32'h0000FFFF);
    busRead(32'h14, rd);
    checkVal("noIrqEn", rd, 32'h0);
    setInput(16'hFFFF);
    busRead(32'h18, rd);
    checkVal("noIrqStat", rd, 32'h0);
    checkVal("noIrq", {31'h0, irq}, 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  off;
      logic [31:0] a;
      off = 3'($urandom_range(0, 7));
      a = $urandom;
      a[4:2] = off;
      @(negedge clk);
      bSel   = ($urandom_range(0, 3) != 0);
      bWrite = $urandom_range(0, 1) == 1;
      bAddr  = a;
      bWData = $urandom;
      if ($urandom_range(0, 2) == 0) gpioInput = 16'($urandom);
      #1 checkVal("rdDuringWr", bRData, modelRead(bSel, off));
      tick();
      bSel = 1'b0; bWrite = 1'b0;
      checkVal("rndOut", {16'h0, gpioOutput}, {16'h0, mOut});
      checkVal("rndIrq", {31'h0, irq}, {31'h0, modelIrq()});
    end

    // Reset in the middle of a write: pins clear at once and the write is lost
    @(negedge clk);
    bSel = 1'b1; bWrite = 1'b1; bAddr = 32'h4; bWData = 32'h0000FFFF;
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkVal("asyncRstOut", {16'h0, gpioOutput}, 32'h0);
    checkVal("asyncRstIrq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bSel = 1'b0; bWrite = 1'b0;
    rst = 1'b1;
    tick();
    checkVal("postRstOut", {16'h0, gpioOutput}, {16'h0, mOut});
    busRead(32'h4, rd);
    checkVal("postRstRd", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/gpio.md
Name: gpio

Overview:
- Memory-mapped 16-bit general-purpose I/O peripheral on the CPU's simple single-cycle bus (bSel/bWrite/bAddr/bWData/bRData).
- Provides:
  - a read-only view of the external input pins;
  - a read/write output register driving the output pins;
  - atomic set/clear/toggle aliases for the output register;
  - optional rising-edge interrupt logic.
- Sits beside memory and other peripherals behind the system address decoder, which drives bSel.

Parameters:
- GPIO_W, 16, pin count of gpioInput/gpioOutput (1..32); bus data above GPIO_W reads 0, writes ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- bSel  in  1  peripheral select from address decoder.
- bWrite  in  1  write strobe; meaningful only with bSel=1.
- bAddr  in  32  byte address; only bAddr[4:2] decoded, other bits ignored.
- bWData  in  32  write data; bits [GPIO_W-1:0] used.
- bRData  out  32  read data, combinational.
- gpioInput  in  GPIO_W  external input pins.
- gpioOutput  out  GPIO_W  external output pins, driven directly from the OUT register.
- irq  out  1  interrupt request, level, active-high; tied 0 when the feature is compiled out.

Behaviour:
Register map (word offsets):
- 0x00 IN, read-only: live gpioInput.
- 0x04 OUT, R/W.
- 0x08 SET, write-only: OUT |= data.
- 0x0C CLR, write-only: OUT &= ~data.
- 0x10 TGL, write-only: OUT ^= data.
- 0x14 IRQ_EN, R/W.
- 0x18 IRQ_STAT, R/W1C.
- 0x1C unmapped.

Writes:
- A write occurs on the rising clk edge when bSel=1 and bWrite=1.
- Writes to IN or unmapped offsets have no effect.
- OUT updates on that edge, so gpioOutput shows the new value after the edge: one-cycle write latency, no wait states.

Reads:
- bRData is combinational from bAddr, zero latency.
- bSel=0 forces bRData=0.
- Write-only and unmapped offsets read 0.
- Bits above GPIO_W read 0.
- Reads have no side effects; bWrite is ignored for the read path, so read data is valid even during a write cycle.
- IN is not synchronised: it reflects gpioInput in the same cycle.

Reset (rst=0, asynchronous):
- OUT, IRQ_EN, IRQ_STAT and the edge-history register all clear to 0.
- gpioOutput=0, irq=0.
- Reset asserted mid-write discards the write.
- bWrite with bSel=0 is ignored.

Optional Feature:
GPIO_IRQ_EN is the macro name.
- Defined:
  - A prev register samples gpioInput every clock (reset 0).
  - rise = gpioInput & ~prev.
  - IRQ_STAT bits set on rise regardless of IRQ_EN.
  - Writing 1 to an IRQ_STAT bit clears it.
  - If an edge and a W1C hit the same bit in the same cycle, the set wins.
  - irq = |(IRQ_STAT & IRQ_EN), registered-free combinational OR.
  - First cycle after reset release: any input high counts as a rise, since prev=0.
- Undefined:
  - No prev/IRQ_EN/IRQ_STAT storage.
  - Offsets 0x14/0x18 read 0 and ignore writes.
  - irq tied 0.
  - The port list is identical in both builds.

Decomposition:
- Package gpio_pkg: offset constants GPIO_OFF_IN/OUT/SET/CLR/TGL/IRQ_EN/IRQ_STAT (3-bit word indices), default width constant.
- One natural sub-module, gpio_edge_detect (prev register + rise vector), instantiated only under GPIO_IRQ_EN.
- The bus decode and OUT logic stay in gpio.

Test Plan:
- Reset held 20 ns, then released -> gpioOutput=0000, read 0x04 -> 0x00000000, irq=0.
- bSel=1,bWrite=1,addr 0x04,data 0x0000AAAA for one clock; then read 0x04 -> bRData[15:0]=AAAA, gpioOutput=AAAA; read during bWrite=0 unchanged.
- gpioInput=55AA, read 0x00 -> 55AA within same cycle; change to F0F0 -> F0F0 next read; upper 16 bits 0.
- Starting from OUT=AAAA: SET 0x000F -> AAAF; CLR 0xA000 -> 0AAF; TGL 0x00FF -> 0A50; reads of 0x08/0x0C/0x10 -> 0.
- bWrite=1 with bSel=0 to 0x04 data FFFF -> OUT unchanged; bSel=0 read -> bRData=0; assert rst mid-sequence -> gpioOutput=0 immediately without waiting for a clock edge.
- (GPIO_IRQ_EN) IRQ_EN=0x0001, gpioInput bit0 0->1 -> IRQ_STAT=0001, irq=1 after that edge; W1C 0x0001 -> irq=0; bit1 rising with IRQ_EN bit1=0 -> IRQ_STAT bit1=1, irq stays 0.
